// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the round-robin bus arbiter.
package bus_arb_pkg;
    localparam int ID_W = 8;
    localparam logic [ID_W-1:0] BROADCAST_DEF = 8'hFF;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;
endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request bit found by
// searching upward from last_grant+1 with wrap.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] last_grant_i,
    output logic         valid_o,
    output logic [W-1:0] winner_o
);
    always_comb begin
        int idx;
        valid_o  = 1'b0;
        winner_o = '0;
        idx      = 0;
        // Walk from the farthest candidate back to the nearest, so the
        // closest requester after last_grant is the one left standing.
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last_grant_i) + k) % N;
            if (req_i[idx]) begin
                valid_o  = 1'b1;
                winner_o = W'(idx);
            end
        end
    end
endmodule

// File: rtl/bus_rr_arbiter.sv
// Shared-bus round-robin arbiter: pops one packet from a source FIFO, then
// pushes it to its destination FIFO(s). Macro BUS_ARB_DROP_CNT_EN adds drop_cnt.
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int              num_ntrfs = 4,
    parameter int              pckg_sz   = 32,
    parameter logic [ID_W-1:0] broadcast = BROADCAST_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [num_ntrfs-1:0]         pndng_in,
    input  logic [num_ntrfs*pckg_sz-1:0] data_in,
    input  logic [num_ntrfs-1:0]         full_in,
    output logic [num_ntrfs-1:0]         pop,
    output logic [num_ntrfs-1:0]         push,
    output logic [pckg_sz-1:0]           data_out,
    output logic                         busy
`ifdef BUS_ARB_DROP_CNT_EN
    ,
    output logic [15:0]                  drop_cnt
`endif
);
    localparam int IDX_W = (num_ntrfs > 1) ? $clog2(num_ntrfs) : 1;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     last_grant_q, last_grant_d;
    logic [pckg_sz-1:0]   data_q, data_d;
    logic [num_ntrfs-1:0] pop_q, pop_d;
    logic [num_ntrfs-1:0] push_q, push_d;
`ifdef BUS_ARB_DROP_CNT_EN
    logic [15:0]          drop_cnt_q, drop_cnt_d;
`endif

    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_winner;
    logic [ID_W-1:0]      dest_id;
    logic [num_ntrfs-1:0] target;

    rr_pick #(
        .N(num_ntrfs),
        .W(IDX_W)
    ) u_rr_pick (
        .req_i       (pndng_in),
        .last_grant_i(last_grant_q),
        .valid_o     (pick_valid),
        .winner_o    (pick_winner)
    );

    // The held packet's source is last_grant_q, so broadcast skips it.
    assign dest_id = data_q[pckg_sz-1 -: ID_W];

    always_comb begin
        target = '0;
        if (dest_id == broadcast) begin
            target               = '1;
            target[last_grant_q] = 1'b0;
        end else if (dest_id < ID_W'(num_ntrfs)) begin
            target[dest_id[IDX_W-1:0]] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        data_d       = data_q;
        pop_d        = '0;
        push_d       = '0;
`ifdef BUS_ARB_DROP_CNT_EN
        drop_cnt_d   = drop_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    data_d             = data_in[int'(pick_winner)*pckg_sz +: pckg_sz];
                    pop_d[pick_winner] = 1'b1;
                    last_grant_d       = pick_winner;
                    state_d            = SEND;
                end
            end
            SEND: begin
                // All targets must be free at once; a zero target always passes.
                if ((target & full_in) == '0) begin
                    push_d  = target;
                    state_d = IDLE;
`ifdef BUS_ARB_DROP_CNT_EN
                    if ((target == '0) && (drop_cnt_q != 16'hFFFF))
                        drop_cnt_d = drop_cnt_q + 16'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(num_ntrfs - 1);
            data_q       <= '0;
            pop_q        <= '0;
            push_q       <= '0;
`ifdef BUS_ARB_DROP_CNT_EN
            drop_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
            pop_q        <= pop_d;
            push_q       <= push_d;
`ifdef BUS_ARB_DROP_CNT_EN
            drop_cnt_q   <= drop_cnt_d;
`endif
        end
    end

    assign pop      = pop_q;
    assign push     = push_q;
    assign data_out = data_q;
    assign busy     = (state_q == SEND);
`ifdef BUS_ARB_DROP_CNT_EN
    assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed self-checking bench for bus_rr_arbiter (4 terminals, 32-bit packets).
module tb_bus_rr_arbiter;
    localparam int N  = 4;
    localparam int PW = 32;

    typedef struct packed {
        logic [N-1:0]  pop;
        logic [N-1:0]  push;
        logic [PW-1:0] data;
        logic          busy;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    pndng_in;
    logic [N*PW-1:0] data_in;
    logic [N-1:0]    full_in;
    logic [N-1:0]    pop;
    logic [N-1:0]    push;
    logic [PW-1:0]   data_out;
    logic            busy;
`ifdef BUS_ARB_DROP_CNT_EN
    logic [15:0]     drop_cnt;
`endif

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    bus_rr_arbiter #(
        .num_ntrfs(N),
        .pckg_sz  (PW),
        .broadcast(8'hFF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .pndng_in(pndng_in),
        .data_in (data_in),
        .full_in (full_in),
        .pop     (pop),
        .push    (push),
        .data_out(data_out),
        .busy    (busy)
`ifdef BUS_ARB_DROP_CNT_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    task automatic chk(input string tag, input string field,
                       input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s.%s: observed %h expected %h", tag, field, got, exp);
        end
    endtask

    task automatic set_word(input int i, input logic [PW-1:0] v);
        data_in[i*PW +: PW] = v;
    endtask

    // Queue the outputs expected after the coming edge, clock, then compare.
    task automatic tick(input string tag, input logic [N-1:0] ep, input logic [N-1:0] eu,
                        input logic [PW-1:0] ed, input logic eb);
        exp_t e;
        sb_q.push_back('{pop: ep, push: eu, data: ed, busy: eb});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk(tag, "pop",  32'(pop),  32'(e.pop));
        chk(tag, "push", 32'(push), 32'(e.push));
        chk(tag, "data", data_out,  e.data);
        chk(tag, "busy", 32'(busy), 32'(e.busy));
        chk(tag, "pop_and_push", 32'(pop & push), 32'd0);
        $display("[%0t] %s pop=%b push=%b data=%h busy=%b", $time, tag, pop, push, data_out, busy);
    endtask

    initial begin
        logic [PW-1:0] w;
        logic [PW-1:0] words[N];
        int            g;

        reset    = 1'b0;
        pndng_in = '0;
        full_in  = '0;
        data_in  = '0;
        #1;
        tick("reset0", 4'b0000, 4'b0000, 32'h0, 1'b0);
        tick("reset1", 4'b0000, 4'b0000, 32'h0, 1'b0);
        reset = 1'b1;
        tick("idle", 4'b0000, 4'b0000, 32'h0, 1'b0);

        // Single packet 0 -> 2
        set_word(0, 32'h02AB_CDEF);
        pndng_in = 4'b0001;
        tick("single_pop", 4'b0001, 4'b0000, 32'h02AB_CDEF, 1'b1);
        pndng_in = 4'b0000;
        tick("single_push", 4'b0000, 4'b0100, 32'h02AB_CDEF, 1'b0);
        tick("single_idle", 4'b0000, 4'b0000, 32'h02AB_CDEF, 1'b0);

        // Fairness from a fresh reset: 0,1,2,3,0, one pop every two cycles
        reset = 1'b0;
        tick("fair_reset", 4'b0000, 4'b0000, 32'h0, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            words[i] = {8'((i + 1) % N), 16'h5A5A, 8'(i)};
            set_word(i, words[i]);
        end
        pndng_in = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            g = k % N;
            tick($sformatf("fair_pop%0d", k), 4'(1 << g), 4'b0000, words[g], 1'b1);
            tick($sformatf("fair_push%0d", k), 4'b0000, 4'(1 << ((g + 1) % N)), words[g], 1'b0);
        end
        pndng_in = 4'b0000;

        // Broadcast from source 1 reaches 0, 2 and 3 together
        set_word(1, 32'hFF00_0001);
        pndng_in = 4'b0010;
        tick("bcast_pop", 4'b0010, 4'b0000, 32'hFF00_0001, 1'b1);
        pndng_in = 4'b0000;
        tick("bcast_push", 4'b0000, 4'b1101, 32'hFF00_0001, 1'b0);

        // Backpressure: source 2 -> 3 while destination 3 is full
        set_word(2, 32'h0300_0022);
        pndng_in = 4'b0100;
        tick("bp_pop", 4'b0100, 4'b0000, 32'h0300_0022, 1'b1);
        pndng_in = 4'b0000;
        full_in  = 4'b1000;
        for (int k = 0; k < 5; k++)
            tick($sformatf("bp_stall%0d", k), 4'b0000, 4'b0000, 32'h0300_0022, 1'b1);
        full_in = 4'b0000;
        tick("bp_push", 4'b0000, 4'b1000, 32'h0300_0022, 1'b0);

        // Broadcast blocked by a single full target
        set_word(3, 32'hFF00_0033);
        pndng_in = 4'b1000;
        tick("bcbp_pop", 4'b1000, 4'b0000, 32'hFF00_0033, 1'b1);
        pndng_in = 4'b0000;
        full_in  = 4'b0010;
        tick("bcbp_stall0", 4'b0000, 4'b0000, 32'hFF00_0033, 1'b1);
        tick("bcbp_stall1", 4'b0000, 4'b0000, 32'hFF00_0033, 1'b1);
        full_in = 4'b0000;
        tick("bcbp_push", 4'b0000, 4'b0111, 32'hFF00_0033, 1'b0);

        // Invalid destination 8'h07 is dropped
        set_word(0, 32'h0700_0000);
        pndng_in = 4'b0001;
        tick("drop_pop", 4'b0001, 4'b0000, 32'h0700_0000, 1'b1);
        pndng_in = 4'b0000;
        tick("drop_leave", 4'b0000, 4'b0000, 32'h0700_0000, 1'b0);
        tick("drop_idle", 4'b0000, 4'b0000, 32'h0700_0000, 1'b0);
`ifdef BUS_ARB_DROP_CNT_EN
        chk("drop", "drop_cnt", 32'(drop_cnt), 32'd1);
`endif

        // Reset while a packet is held discards it
        set_word(1, 32'h0000_0011);
        pndng_in = 4'b0010;
        tick("rsend_pop", 4'b0010, 4'b0000, 32'h0000_0011, 1'b1);
        pndng_in = 4'b0000;
        reset    = 1'b0;
        tick("rsend_reset", 4'b0000, 4'b0000, 32'h0, 1'b0);
        reset = 1'b1;
        tick("rsend_after0", 4'b0000, 4'b0000, 32'h0, 1'b0);
        tick("rsend_after1", 4'b0000, 4'b0000, 32'h0, 1'b0);
`ifdef BUS_ARB_DROP_CNT_EN
        chk("rsend", "drop_cnt", 32'(drop_cnt), 32'd0);
`endif

        // First grant after reset goes to terminal 0
        w = 32'h0100_00A0;
        set_word(0, w);
        pndng_in = 4'b0011;
        tick("post_rst_pop", 4'b0001, 4'b0000, w, 1'b1);
        pndng_in = 4'b0000;
        tick("post_rst_push", 4'b0000, 4'b0010, w, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bus_rr_arbiter.md
BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

Interface
REQ-001 SHALL have parameter num_ntrfs, default 4, number of terminals on the shared bus (2..16).
REQ-002 SHALL have parameter pckg_sz, default 32, packet width in bits (min 16).
REQ-003 SHALL have parameter broadcast, default 8'hFF, destination ID meaning all terminals.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on posedge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-low.
REQ-006 SHALL have port pndng_in, input, num_ntrfs, bit i high = source FIFO i non-empty.
REQ-007 SHALL have port data_in, input, num_ntrfs*pckg_sz, first-word-fall-through head of source FIFO i in slice i.
REQ-008 SHALL have port full_in, input, num_ntrfs, bit i high = destination FIFO i full.
REQ-009 SHALL have port pop, output, num_ntrfs, one-hot pop strobe to source FIFOs.
REQ-010 SHALL have port push, output, num_ntrfs, push strobe(s) to destination FIFOs.
REQ-011 SHALL have port data_out, output, pckg_sz, registered packet driven on the bus.
REQ-012 SHALL have port busy, output, 1, high while a packet is held (state SEND).

Function
REQ-013 SHALL take the destination ID from data bits [pckg_sz-1 -: 8].
REQ-014 SHALL implement FSM states IDLE and SEND; all outputs registered.
REQ-015 In IDLE with pndng_in != 0, SHALL grant the first set bit searching from (last_grant+1) mod num_ntrfs upward with wrap; at that edge it SHALL latch data_in[winner] into data_out, assert pop[winner] for exactly one cycle, update last_grant, and enter SEND.
REQ-016 In IDLE with pndng_in == 0, SHALL hold pop = 0, push = 0, last_grant, and data_out unchanged.
REQ-017 SHALL form the target mask in SEND as: ID == broadcast -> all ones except the source bit; ID < num_ntrfs -> one-hot(ID), including ID == source; otherwise -> zero (drop).
REQ-018 In SEND, if (target & full_in) == 0, SHALL assert push = target for exactly one cycle and return to IDLE; otherwise SHALL stall in SEND with push = 0 and data_out held, and SHALL complete broadcast atomically (all targets pushed in the same cycle).
REQ-019 A dropped packet (zero target) SHALL leave SEND after one cycle with no push.
REQ-020 Latency: pndng_in sampled high at edge N -> pop high in cycle N+1 -> push high in cycle N+2 when unblocked; sustained throughput is one packet per 2 cycles.
REQ-021 pop SHALL never be asserted while in SEND, and pop and push SHALL never be high in the same cycle.
REQ-022 A source whose pndng_in bit drops while it is not granted SHALL simply be skipped; no state is kept per source except last_grant.

Reset
REQ-023 While reset is low at a clock edge, SHALL force state IDLE, pop = 0, push = 0, data_out = 0, busy = 0, and last_grant = num_ntrfs-1, so terminal 0 has first priority.
REQ-024 Reset asserted in SEND SHALL discard the held packet with no push issued.

Configuration
REQ-025 With macro BUS_ARB_DROP_CNT_EN defined, SHALL add output drop_cnt [15:0], incremented on each REQ-019 drop, saturating at 16'hFFFF and cleared by reset.
REQ-026 Without BUS_ARB_DROP_CNT_EN, drop_cnt SHALL not exist and drops SHALL still occur silently.

Structure
REQ-027 Package bus_arb_pkg SHALL hold the state enum (IDLE, SEND), the ID width constant (8), and the default broadcast value.
REQ-028 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs: request vector and last_grant; outputs: valid and winner index).

Verification
REQ-029 Single packet: pndng_in = 4'b0001, data_in[0] = 32'h02AB_CDEF -> pop = 4'b0001 one cycle, then push = 4'b0100 and data_out = 32'h02AB_CDEF.
REQ-030 Fairness: all four sources permanently pending -> grant order 0,1,2,3,0 with one pop per 2 cycles.
REQ-031 Broadcast: source 1 sends 32'hFF00_0001 -> push = 4'b1101 in a single cycle.
REQ-032 Backpressure: target 3 with full_in[3] = 1 for 5 cycles -> busy held, push = 0, data_out stable; push = 4'b1000 in the cycle after full_in[3] falls; a broadcast stalls if any one target is full.
REQ-033 Invalid ID 8'h07 with num_ntrfs = 4 -> pop once, no push, drop_cnt = 1 when BUS_ARB_DROP_CNT_EN is defined.
REQ-034 Reset low during SEND -> no push in any later cycle for that packet; all outputs 0 in the cycle after the reset edge; the first grant after reset goes to terminal 0.
